// File: rtl/icache_pkg.sv
// icache_pkg: shared FSM states and width helper for the direct-mapped instruction cache.
package icache_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/icache_dm_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (inc_i && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped instruction cache with zero-latency hits and a block-wide fill FSM.
module icache_dm
  import icache_pkg::*;
#(
  parameter  int ADDR_W          = 10,
  parameter  int NUM_BLOCKS      = 8,
  parameter  int WORDS_PER_BLOCK = 4,
  parameter  int CNT_W           = 16,
  localparam int OFF_W           = clog2(WORDS_PER_BLOCK),
  localparam int IDX_W           = clog2(NUM_BLOCKS),
  localparam int TAG_W           = ADDR_W - 2 - OFF_W - IDX_W,
  localparam int BADDR_W         = ADDR_W - 2 - OFF_W
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [31:0]                  PC,
  input  logic                         FLUSH,
  output logic [31:0]                  INSTRUCTION,
  output logic                         busywait,
  output logic                         mem_read,
  output logic [BADDR_W-1:0]           mem_address,
  input  logic [32*WORDS_PER_BLOCK-1:0] mem_readdata,
  input  logic                         mem_busywait,
  output logic [CNT_W-1:0]             hit_count,
  output logic [CNT_W-1:0]             miss_count
);
  localparam int OW = OFF_W > 0 ? OFF_W : 1;
  state_t                        state_q;
  logic [BADDR_W-1:0]            addr_q;
  logic [NUM_BLOCKS-1:0]         valid_q;
  logic                          flush_q;
  logic [31:0]                   instr_q;
  logic [32*WORDS_PER_BLOCK-1:0] line_q;
  logic [32*WORDS_PER_BLOCK-1:0] data_q [NUM_BLOCKS];
  logic [TAG_W-1:0]              tag_q  [NUM_BLOCKS];
  logic [ADDR_W-3:0]             waddr;
  logic [BADDR_W-1:0]            baddr;
  logic [IDX_W-1:0]              idx, aidx;
  logic [TAG_W-1:0]              tag;
  logic [OW-1:0]                 off;
  logic                          hit, idle_hit, idle_miss;
  logic [2:0]                    unused_pc;
  assign unused_pc   = {^PC[31:ADDR_W], PC[1:0]};
  assign waddr       = PC[ADDR_W-1:2];
  assign baddr       = waddr[ADDR_W-3:OFF_W];
  assign idx         = baddr[IDX_W-1:0];
  assign tag         = baddr[BADDR_W-1:IDX_W];
  assign off         = OFF_W == 0 ? '0 : OW'(waddr);
  assign aidx        = addr_q[IDX_W-1:0];
  assign hit         = valid_q[idx] && tag_q[idx] == tag;
  assign idle_hit    = state_q == IDLE && hit;
  assign idle_miss   = state_q == IDLE && !hit;
  assign INSTRUCTION = idle_hit ? data_q[idx][32*off +: 32] : instr_q;
  assign busywait    = RESET && (state_q != IDLE || !hit);
  assign mem_read    = state_q == MEM_READ;
  assign mem_address = addr_q;
  // A flush seen mid-fill is deferred so it also drops the line being filled.
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      valid_q <= '0;
      flush_q <= 1'b0;
      instr_q <= '0;
    end else begin
      instr_q <= INSTRUCTION;
      case (state_q)
        IDLE: begin
          if (FLUSH) valid_q <= '0;
          if (!hit) begin
            addr_q  <= baddr;
            state_q <= MEM_READ;
          end
        end
        MEM_READ: begin
          flush_q <= flush_q | FLUSH;
          if (!mem_busywait) state_q <= UPDATE;
        end
        default: begin
          valid_q <= (flush_q || FLUSH) ? '0 : valid_q | (NUM_BLOCKS'(1) << aidx);
          flush_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  always_ff @(posedge CLK) begin
    if (state_q == MEM_READ && !mem_busywait) line_q <= mem_readdata;
    if (state_q == UPDATE) begin
      data_q[aidx] <= line_q;
      tag_q[aidx]  <= addr_q[BADDR_W-1:IDX_W];
    end
  end
  sat_counter #(.W(CNT_W)) u_hits (
    .clk  (CLK),
    .rst_n(RESET),
    .inc_i(idle_hit),
    .cnt_o(hit_count)
  );
  sat_counter #(.W(CNT_W)) u_misses (
    .clk  (CLK),
    .rst_n(RESET),
    .inc_i(idle_miss),
    .cnt_o(miss_count)
  );
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed and random fetches checked against a line-level cache model and timing rule.
module tb_icache_dm;
  localparam int LAT = 5;
  logic         CLK, RESET, FLUSH, busywait, mem_read, mem_busywait;
  logic [31:0]  PC, INSTRUCTION;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic [15:0]  hit_count, miss_count;
  logic [31:0]  mem_words [256];
  logic [7:0]   mv;
  logic [2:0]   mt [8];
  int hit_m, miss_m, mcnt, checks, errors;

  icache_dm dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .FLUSH(FLUSH), .INSTRUCTION(INSTRUCTION),
    .busywait(busywait), .mem_read(mem_read), .mem_address(mem_address),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int sat(input int v);
    return v >= 65535 ? 65535 : v + 1;
  endfunction

  function automatic logic [127:0] line_of(input logic [5:0] b);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = mem_words[{b, 2'(k)}];
    return l;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory answers LAT cycles into each read: busy for LAT-1 cycles, then data.
  task automatic mem_drive();
    if (mem_read) begin
      mcnt++;
      mem_busywait = mcnt < LAT;
      mem_readdata = mem_busywait ? {$urandom, $urandom, $urandom, $urandom} : line_of(mem_address);
    end else begin
      mcnt = 0;
      mem_busywait = 1'b0;
      mem_readdata = '0;
    end
  endtask

  // One fetch: fl_at = cycle index of a FLUSH pulse (0 = with the request, <0 = none).
  task automatic fetch(input logic [31:0] pc, input int fl_at);
    logic [5:0] b;
    logic [2:0] i, t;
    logic       mhit, pend;
    int         n;
    b = pc[9:4];
    i = b[2:0];
    t = b[5:3];
    mhit = mv[i] && mt[i] == t;
    pend = !mhit && fl_at > 0 && fl_at <= LAT + 1;
    PC = pc;
    FLUSH = fl_at == 0;
    mem_drive();
    #1;
    chk("bw_first", 32'(busywait), 32'(!mhit));
    if (!mhit) begin
      if (fl_at == 0) mv = '0;
      n = 0;
      while (busywait && n < 40) begin
        @(posedge CLK);
        #1;
        n++;
        if (n == 1 || (pend && n == LAT + 3)) miss_m = sat(miss_m);
        FLUSH = fl_at == n;
        mem_drive();
        #1;
        if (n == 1) begin
          chk("mem_read", 32'(mem_read), 32'd1);
          chk("mem_addr", 32'(mem_address), 32'(b));
        end
      end
      chk("penalty", n, pend ? 2 * (LAT + 2) : LAT + 2);
      if (pend) mv = '0;
      mv[i] = 1'b1;
      mt[i] = t;
    end
    chk("instr", INSTRUCTION, mem_words[pc[9:2]]);
    chk("hit_cnt", 32'(hit_count), hit_m);
    chk("miss_cnt", 32'(miss_count), miss_m);
    @(posedge CLK);
    #1;
    FLUSH = 1'b0;
    hit_m = sat(hit_m);
    if (fl_at == 0 && mhit) mv = '0;
  endtask

  task automatic model_reset();
    mv = '0;
    hit_m = 0;
    miss_m = 0;
  endtask

  initial begin
    int r, fl;
    logic [31:0] pc;
    checks = 0;
    errors = 0;
    mcnt = 0;
    for (int k = 0; k < 256; k++) mem_words[k] = $urandom;
    RESET = 1'b1;
    PC = '0;
    FLUSH = 1'b0;
    mem_busywait = 1'b0;
    mem_readdata = '0;
    #2 RESET = 1'b0;
    #1;
    model_reset();
    chk("rst_instr", INSTRUCTION, 32'd0);
    chk("rst_bw", 32'(busywait), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_addr", 32'(mem_address), 32'd0);
    chk("rst_hits", 32'(hit_count), 32'd0);
    chk("rst_misses", 32'(miss_count), 32'd0);
    @(posedge CLK);
    #1 RESET = 1'b1;
    // cold miss, then sequential hits in the same line
    fetch(32'h000, -1);
    fetch(32'h004, -1);
    fetch(32'h008, -1);
    fetch(32'h00C, -1);
    // conflicting tag evicts index 0
    fetch(32'h080, -1);
    fetch(32'h000, -1);
    // flush pulse during the fill of 0x010 drops the filled line
    fetch(32'h010, 2);
    fetch(32'h014, -1);
    // flush in IDLE alongside a hit
    fetch(32'h018, 0);
    fetch(32'h01C, -1);
    // reset mid-fill aborts
    PC = 32'h020;
    mem_drive();
    #1;
    chk("rf_bw", 32'(busywait), 32'd1);
    repeat (2) begin
      @(posedge CLK);
      #1;
      mem_drive();
    end
    #1;
    chk("rf_mem_read_before", 32'(mem_read), 32'd1);
    RESET = 1'b0;
    #1;
    model_reset();
    chk("rf_mem_read", 32'(mem_read), 32'd0);
    chk("rf_bw_low", 32'(busywait), 32'd0);
    chk("rf_mem_addr", 32'(mem_address), 32'd0);
    chk("rf_misses", 32'(miss_count), 32'd0);
    @(posedge CLK);
    #1 RESET = 1'b1;
    fetch(32'h000, -1);
    fetch(32'h020, -1);
    // random traffic over two tags, upper PC bits scrambled
    for (int k = 0; k < 80; k++) begin
      pc = ($urandom << 10) | (32'($urandom_range(0, 1)) << 7) |
           (32'($urandom_range(0, 7)) << 4) | (32'($urandom_range(0, 3)) << 2);
      r = $urandom_range(0, 9);
      fl = r == 0 ? 0 : r == 1 ? $urandom_range(1, LAT + 1) : -1;
      fetch(pc, fl);
    end
    // hit counter saturation on a stalled PC
    fetch(32'h000, -1);
    FLUSH = 1'b0;
    while (hit_m < 65534) begin
      @(posedge CLK);
      hit_m = sat(hit_m);
    end
    #1;
    chk("hit_near_sat", 32'(hit_count), 32'd65534);
    repeat (3) @(posedge CLK);
    #1;
    chk("hit_sat", 32'(hit_count), 32'h0000FFFF);
    chk("miss_after_sat", 32'(miss_count), miss_m);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
